cacheline_adaptor: RTL and testbench

- Sits directly downstream of the cache controller/datapath, between the cache's 256-bit pmem port and the 64-bit burst memory interface.
- Converts a single cache line read or write-back request into a 4-beat burst on the memory side.
- Returns one `resp_o` pulse to the cache when the whole line has been transferred.

---
 rtl/cacheline_adaptor.sv | 228 ++++++++++++++++++++++
 tb/tb_cacheline_adaptor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// cacheline_adaptor
//
// Bridges the cache's 256-bit pmem port to a 64-bit burst memory interface.
// A line read becomes a 4-beat read burst and a line write-back becomes a
// 4-beat write burst. One resp_o pulse is returned per line.
//
// Ports:
//   clk        clock, all state changes on posedge
//   rst        asynchronous reset, active-low
//   line_i     write-back line from the cache
//   line_o     filled line to the cache (the internal line buffer)
//   address_i  line address from the cache
//   read_i     cache line read request
//   write_i    cache line write request (wins over read_i)
//   resp_o     one-cycle pulse when the whole line has been transferred
//   burst_i    read beat from memory
//   burst_o    write beat to memory
//   address_o  line-aligned burst address to memory
//   read_o     memory burst read
//   write_o    memory burst write
//   resp_i     memory beat accepted / valid
//   err_o      sticky watchdog error (only with CACHELINE_ADAPTOR_TIMEOUT_EN)
//
// Optional feature: define CACHELINE_ADAPTOR_TIMEOUT_EN to add a watchdog
// that abandons a burst after TIMEOUT_CYCLES cycles without resp_i.
// -----------------------------------------------------------------------------
module cacheline_adaptor #(
   parameter int LINE_WIDTH  = 256,
   parameter int BURST_WIDTH = 64,
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
   parameter int ADDR_WIDTH  = 32,
   parameter int TIMEOUT_CYCLES = 1024
`else
   parameter int ADDR_WIDTH  = 32
`endif
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [LINE_WIDTH-1:0]  line_i,
   output logic [LINE_WIDTH-1:0]  line_o,
   input  logic [ADDR_WIDTH-1:0]  address_i,
   input  logic                   read_i,
   input  logic                   write_i,
   output logic                   resp_o,
   input  logic [BURST_WIDTH-1:0] burst_i,
   output logic [BURST_WIDTH-1:0] burst_o,
   output logic [ADDR_WIDTH-1:0]  address_o,
   output logic                   read_o,
   output logic                   write_o,
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
   input  logic                   resp_i,
   output logic                   err_o
`else
   input  logic                   resp_i
`endif
);

   localparam int BEATS  = LINE_WIDTH / BURST_WIDTH;
   localparam int BEAT_W = $clog2(BEATS);
   localparam int OFF_W  = $clog2(LINE_WIDTH / 8);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [BEAT_W-1:0]      beat_q, beat_d;
   logic [LINE_WIDTH-1:0]  line_q, line_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [BURST_WIDTH-1:0] burst_q, burst_d;
   logic                   read_q, read_d;
   logic                   write_q, write_d;
   logic                   resp_q, resp_d;
   logic [ADDR_WIDTH-1:0]  line_addr_s;
   logic                   unused_s;

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   err_q, err_d;
`endif

   // Byte offset within the line is dropped: bursts always start line-aligned.
   assign line_addr_s = {address_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
   assign unused_s    = ^address_i[OFF_W-1:0];

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      line_d  = line_q;
      addr_d  = addr_q;
      burst_d = {BURST_WIDTH{1'b0}};
      read_d  = 1'b0;
      write_d = 1'b0;
      resp_d  = 1'b0;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (write_i) begin
               line_d  = line_i;
               addr_d  = line_addr_s;
               beat_d  = {BEAT_W{1'b0}};
               state_d = WR;
            end else if (read_i) begin
               addr_d  = line_addr_s;
               beat_d  = {BEAT_W{1'b0}};
               state_d = RD;
            end else begin
               state_d = IDLE;
            end
         end
         RD: begin
            if (resp_i) begin
               for (int b = 0; b < BEATS; b++) begin
                  if (beat_q == BEAT_W'(b)) begin
                     line_d[b*BURST_WIDTH +: BURST_WIDTH] = burst_i;
                  end else begin
                     line_d[b*BURST_WIDTH +: BURST_WIDTH] = line_q[b*BURST_WIDTH +: BURST_WIDTH];
                  end
               end
               beat_d  = beat_q + BEAT_W'(1);
               state_d = (beat_q == LAST_BEAT) ? DONE : RD;
            end else begin
               state_d = RD;
            end
         end
         WR: begin
            if (resp_i) begin
               beat_d  = beat_q + BEAT_W'(1);
               state_d = (beat_q == LAST_BEAT) ? DONE : WR;
            end else begin
               state_d = WR;
            end
         end
         DONE: begin
            // Requests are not sampled here; the cache drops them on resp_o.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
      // Watchdog: abandon the burst so the cache never waits forever.
      if ((state_q == RD) || (state_q == WR)) begin
         if (resp_i) begin
            cnt_d = {CNT_W{1'b0}};
         end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            cnt_d   = {CNT_W{1'b0}};
            err_d   = 1'b1;
            state_d = DONE;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = {CNT_W{1'b0}};
      end
`endif

      // Outputs are registered, so derive them from the next state.
      read_d  = (state_d == RD);
      write_d = (state_d == WR);
      resp_d  = (state_d == DONE);
      if (state_d == WR) begin
         for (int b = 0; b < BEATS; b++) begin
            if (beat_d == BEAT_W'(b)) begin
               burst_d = line_d[b*BURST_WIDTH +: BURST_WIDTH];
            end else begin
               burst_d = burst_d;
            end
         end
      end else begin
         burst_d = {BURST_WIDTH{1'b0}};
      end
   end

   // State, datapath and output registers; reset aborts any burst at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         beat_q  <= {BEAT_W{1'b0}};
         line_q  <= {LINE_WIDTH{1'b0}};
         addr_q  <= {ADDR_WIDTH{1'b0}};
         burst_q <= {BURST_WIDTH{1'b0}};
         read_q  <= 1'b0;
         write_q <= 1'b0;
         resp_q  <= 1'b0;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
         cnt_q   <= {CNT_W{1'b0}};
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         line_q  <= line_d;
         addr_q  <= addr_d;
         burst_q <= burst_d;
         read_q  <= read_d;
         write_q <= write_d;
         resp_q  <= resp_d;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   assign line_o    = line_q;
   assign address_o = addr_q;
   assign burst_o   = burst_q;
   assign read_o    = read_q;
   assign write_o   = write_q;
   assign resp_o    = resp_q;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
   assign err_o     = err_q;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// tb_cacheline_adaptor: directed self-checking bench for cacheline_adaptor.
// Inputs change 1 time unit after posedge; outputs are sampled there too, so
// "cycle Tn" below is the interval after the n-th edge following the accept.
// -----------------------------------------------------------------------------
module tb_cacheline_adaptor;

   logic         clk;
   logic         rst;
   logic [255:0] line_i;
   logic [255:0] line_o;
   logic [31:0]  address_i;
   logic         read_i;
   logic         write_i;
   logic         resp_o;
   logic [63:0]  burst_i;
   logic [63:0]  burst_o;
   logic [31:0]  address_o;
   logic         read_o;
   logic         write_o;
   logic         resp_i;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
   logic         err_o;
`endif

   int pass_cnt  = 0;
   int check_cnt = 0;

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
   cacheline_adaptor #(.TIMEOUT_CYCLES(16)) dut (
`else
   cacheline_adaptor dut (
`endif
      .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
      .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
      .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
      .read_o(read_o), .write_o(write_o),
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
      .resp_i(resp_i), .err_o(err_o)
`else
      .resp_i(resp_i)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
      burst_i = '0; resp_i = 1'b0;
      tick();
      check_cnt++; if (line_o !== 256'd0) $display("FAIL reset_line_o: got %h want 0", line_o); else pass_cnt++;
      check_cnt++; if (burst_o !== 64'd0) $display("FAIL reset_burst_o: got %h want 0", burst_o); else pass_cnt++;
      check_cnt++; if (address_o !== 32'd0) $display("FAIL reset_address_o: got %h want 0", address_o); else pass_cnt++;
      check_cnt++; if ({read_o, write_o, resp_o} !== 3'b000) $display("FAIL reset_ctrl: got %b want 000", {read_o, write_o, resp_o}); else pass_cnt++;
      rst = 1'b1;
      tick();
   endtask

   task automatic test_idle_resp();
      resp_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_cnt++; if ({read_o, write_o, resp_o} !== 3'b000) $display("FAIL idle_resp_ignored: got %b want 000", {read_o, write_o, resp_o}); else pass_cnt++;
      end
      resp_i = 1'b0;
   endtask

   task automatic test_read();
      logic [63:0] beats [4];
      beats[0] = 64'h1111_1111_1111_1111; beats[1] = 64'h2222_2222_2222_2222;
      beats[2] = 64'h3333_3333_3333_3333; beats[3] = 64'h4444_4444_4444_4444;
      address_i = 32'h0000_1234; read_i = 1'b1;        // T0 accept
      for (int k = 0; k < 4; k++) begin
         tick();                                        // T1..T4
         check_cnt++; if (read_o !== 1'b1) $display("FAIL read_read_o T%0d: got %b want 1", k + 1, read_o); else pass_cnt++;
         check_cnt++; if (address_o !== 32'h0000_1220) $display("FAIL read_address_o T%0d: got %h want 00001220", k + 1, address_o); else pass_cnt++;
         check_cnt++; if (resp_o !== 1'b0) $display("FAIL read_early_resp T%0d: got %b want 0", k + 1, resp_o); else pass_cnt++;
         address_i = 32'hFFFF_FFFF;                     // ignored mid-burst
         resp_i = 1'b1; burst_i = beats[k];
      end
      tick();                                           // T5
      resp_i = 1'b0; burst_i = '0;
      check_cnt++; if (resp_o !== 1'b1) $display("FAIL read_resp_T5: got %b want 1", resp_o); else pass_cnt++;
      check_cnt++; if (read_o !== 1'b0) $display("FAIL read_read_o_done: got %b want 0", read_o); else pass_cnt++;
      check_cnt++; if (line_o !== {beats[3], beats[2], beats[1], beats[0]}) $display("FAIL read_line_o: got %h want %h", line_o, {beats[3], beats[2], beats[1], beats[0]}); else pass_cnt++;
      read_i = 1'b0;
      tick();                                           // T6 IDLE
      check_cnt++; if (resp_o !== 1'b0) $display("FAIL read_resp_single: got %b want 0", resp_o); else pass_cnt++;
      check_cnt++; if (line_o !== {beats[3], beats[2], beats[1], beats[0]}) $display("FAIL read_line_hold: got %h", line_o); else pass_cnt++;
   endtask

   task automatic test_write_stall();
      logic [63:0] d [4];
      logic [3:0]  rsp_seq [7];
      logic [1:0]  exp_idx [7];
      d[0] = 64'hD0D0_0000_0000_00D0; d[1] = 64'hD1D1_1111_0000_00D1;
      d[2] = 64'hD2D2_2222_0000_00D2; d[3] = 64'hD3D3_3333_0000_00D3;
      line_i = {d[3], d[2], d[1], d[0]}; address_i = 32'h0000_0400; write_i = 1'b1;   // T0
      // Per cycle T1..T6: expected burst index and resp_i driven in that cycle.
      exp_idx[0] = 2'd0; exp_idx[1] = 2'd1; exp_idx[2] = 2'd1; exp_idx[3] = 2'd1; exp_idx[4] = 2'd2; exp_idx[5] = 2'd3;
      rsp_seq[0] = 4'd1; rsp_seq[1] = 4'd0; rsp_seq[2] = 4'd0; rsp_seq[3] = 4'd1; rsp_seq[4] = 4'd1; rsp_seq[5] = 4'd1;
      for (int k = 0; k < 6; k++) begin
         tick();
         check_cnt++; if (write_o !== 1'b1) $display("FAIL write_write_o T%0d: got %b want 1", k + 1, write_o); else pass_cnt++;
         check_cnt++; if (burst_o !== d[exp_idx[k]]) $display("FAIL write_burst_o T%0d: got %h want %h", k + 1, burst_o, d[exp_idx[k]]); else pass_cnt++;
         check_cnt++; if (resp_o !== 1'b0) $display("FAIL write_early_resp T%0d: got %b want 0", k + 1, resp_o); else pass_cnt++;
         line_i = ~line_i;                              // ignored mid-burst
         resp_i = rsp_seq[k][0];
      end
      tick();                                           // T7
      resp_i = 1'b0;
      check_cnt++; if (resp_o !== 1'b1) $display("FAIL write_resp_T7: got %b want 1", resp_o); else pass_cnt++;
      check_cnt++; if (write_o !== 1'b0) $display("FAIL write_write_o_done: got %b want 0", write_o); else pass_cnt++;
      write_i = 1'b0;
      tick();
   endtask

   task automatic test_simultaneous();
      int rd_seen = 0;
      line_i = {4{64'hA5A5_5A5A_0F0F_F0F0}}; address_i = 32'h0000_0800;
      read_i = 1'b1; write_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (read_o) rd_seen++;
         if (k == 0) begin
            check_cnt++; if (write_o !== 1'b1) $display("FAIL simul_write_wins: got %b want 1", write_o); else pass_cnt++;
         end
         resp_i = (k < 4);
      end
      resp_i = 1'b0;
      check_cnt++; if (resp_o !== 1'b1) $display("FAIL simul_resp: got %b want 1", resp_o); else pass_cnt++;
      check_cnt++; if (rd_seen !== 0) $display("FAIL simul_no_read: got %0d read cycles want 0", rd_seen); else pass_cnt++;
      read_i = 1'b0; write_i = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      int resp_seen = 0;
      logic [63:0] rb [4];
      rb[0] = 64'h0123_4567_89AB_CDEF; rb[1] = 64'hFEDC_BA98_7654_3210;
      rb[2] = 64'hCAFE_F00D_DEAD_BEEF; rb[3] = 64'h0000_FFFF_5555_AAAA;
      line_i = {4{64'h7777_8888_9999_0000}}; address_i = 32'h0000_0100; write_i = 1'b1;
      for (int k = 0; k < 5; k++) begin                 // T1..T5 of the write
         tick();
         if (resp_o) resp_seen++;
         if (k < 4) begin
            check_cnt++; if (address_o !== 32'h0000_0100) $display("FAIL b2b_wr_addr T%0d: got %h want 00000100", k + 1, address_o); else pass_cnt++;
         end
         resp_i = (k < 4);
      end
      resp_i = 1'b0; write_i = 1'b0;
      tick();                                           // IDLE: present read
      if (resp_o) resp_seen++;
      address_i = 32'h2000_0047; read_i = 1'b1;
      check_cnt++; if (address_o !== 32'h0000_0100) $display("FAIL b2b_addr_before_accept: got %h want 00000100", address_o); else pass_cnt++;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (resp_o) resp_seen++;
         if (k == 0) begin
            check_cnt++; if (address_o !== 32'h2000_0040) $display("FAIL b2b_rd_addr: got %h want 20000040", address_o); else pass_cnt++;
         end
         if (k < 4) begin
            resp_i = 1'b1; burst_i = rb[k];
         end else begin
            resp_i = 1'b0; read_i = 1'b0;
         end
      end
      check_cnt++; if (line_o !== {rb[3], rb[2], rb[1], rb[0]}) $display("FAIL b2b_rd_line: got %h", line_o); else pass_cnt++;
      tick();
      if (resp_o) resp_seen++;
      check_cnt++; if (resp_seen !== 2) $display("FAIL b2b_resp_count: got %0d want 2", resp_seen); else pass_cnt++;
   endtask

   task automatic test_reset_mid_read();
      address_i = 32'h0000_3000; read_i = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         resp_i = 1'b1; burst_i = 64'h9999_0000_0000_0001 + 64'(k);
      end
      tick();                                           // T3: beat 2 pending
      resp_i = 1'b0; read_i = 1'b0;
      check_cnt++; if (read_o !== 1'b1) $display("FAIL rstmid_pre_read_o: got %b want 1", read_o); else pass_cnt++;
      rst = 1'b0;
      #1;
      check_cnt++; if (read_o !== 1'b0) $display("FAIL rstmid_read_o: got %b want 0", read_o); else pass_cnt++;
      check_cnt++; if (line_o !== 256'd0) $display("FAIL rstmid_line_o: got %h want 0", line_o); else pass_cnt++;
      tick();
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_cnt++; if ({read_o, resp_o} !== 2'b00) $display("FAIL rstmid_after: got %b want 00", {read_o, resp_o}); else pass_cnt++;
      end
   endtask

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
   task automatic test_timeout();
      address_i = 32'h0000_5000; read_i = 1'b1; resp_i = 1'b0;
      for (int k = 0; k < 16; k++) tick();              // T16
      check_cnt++; if ({read_o, err_o} !== 2'b10) $display("FAIL timeout_pre: got %b want 10", {read_o, err_o}); else pass_cnt++;
      tick();                                           // T17
      read_i = 1'b0;
      check_cnt++; if ({err_o, read_o, resp_o} !== 3'b101) $display("FAIL timeout_fire: got %b want 101", {err_o, read_o, resp_o}); else pass_cnt++;
      tick();
      check_cnt++; if ({err_o, read_o, resp_o} !== 3'b100) $display("FAIL timeout_sticky: got %b want 100", {err_o, read_o, resp_o}); else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_idle_resp();
      test_read();
      test_write_stall();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid_read();
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
